// File: rtl/stream_pkg.sv
// Shared constants and helpers for the stream buffer slice.
package stream_pkg;

  localparam int RL0 = 0;
  localparam int RL1 = 1;
  localparam int STALL_LIMIT = 64;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_fifo_rl_if.sv
// Upstream/downstream handshake bundle for stream_fifo_rl; slave is the buffer's view.
interface stream_fifo_rl_if #(
  parameter int DATA_WIDTH = 26
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/stream_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module stream_fifo_mem
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = 26,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]     rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo_rl.sv
// Ready/valid circular FIFO with downstream ready latency 0 or 1.
// Optional fill level and stall monitor under `STREAM_FIFO_LEVEL_EN.
module stream_fifo_rl
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH    = 26,
  parameter int DEPTH         = 4,
  parameter int READY_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_fifo_rl_if.slave       bus
`ifdef STREAM_FIFO_LEVEL_EN
  ,
  output logic [clog2(DEPTH):0] fill_level,
  output logic                  overflow_seen
`endif
);

  localparam int ADDR_W = clog2(DEPTH);

  logic [ADDR_W:0]       wr_ptr;
  logic [ADDR_W:0]       rd_ptr;
  logic [ADDR_W:0]       count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  ready_d;
  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] hold_q;

  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == (ADDR_W+1)'(DEPTH));
  assign empty        = (count == '0);
  assign bus.in_ready = ~full & ~rst;
  assign push         = bus.in_valid & bus.in_ready;

  generate
    if (READY_LATENCY == RL0) begin : g_rl0
      assign bus.out_valid = ~empty;
      assign pop           = ~empty & bus.out_ready;
    end else begin : g_rl1
      assign bus.out_valid = ~empty & ready_d;
      assign pop           = ~empty & ready_d;
    end
  endgenerate

  // Once drained, present the last popped beat rather than a stale slot.
  assign bus.out_data = empty ? hold_q : rdata;

  stream_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.in_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_d <= 1'b0;
      hold_q  <= '0;
    end else begin
      ready_d <= bus.out_ready;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold_q <= rdata;
      end
    end
  end

`ifdef STREAM_FIFO_LEVEL_EN
  localparam int STALL_W = clog2(STALL_LIMIT) + 1;

  logic [STALL_W-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_level    <= '0;
      stall_cnt     <= '0;
      overflow_seen <= 1'b0;
    end else begin
      fill_level <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      // Counter saturates; the 64th consecutive stalled cycle sets the flag.
      if (bus.in_valid && !bus.in_ready) begin
        if (stall_cnt == STALL_W'(STALL_LIMIT - 1)) begin
          overflow_seen <= 1'b1;
        end else begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`endif

endmodule

// File: doc/stream_fifo_rl.md
Name: stream_fifo_rl

Overview:
- Parametrised ready/valid stream buffer: DEPTH-entry circular FIFO replacing single-register stream stages in the camera vision pipeline.
- Upstream side is plain ready/valid with ready latency 0.
- Downstream ready latency is selectable at 0 or 1. RL=1 matches Avalon-ST sinks in the Qsys system.
- Absorbs bursts from pixel-processing stages while back-pressure propagates.

Parameters:
- DATA_WIDTH, 26, payload width in bits; RGB plus sop/eop sideband packed by the user.
- DEPTH, 4, number of entries; power of two, at least 2.
- READY_LATENCY, 1, downstream ready latency; legal values 0 or 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream data valid.
- in_ready  out  1  buffer can accept a beat this cycle.
- in_data  in  DATA_WIDTH  upstream payload.
- out_valid  out  1  downstream beat present.
- out_ready  in  1  downstream ready, interpreted per READY_LATENCY.
- out_data  out  DATA_WIDTH  downstream payload.

Behaviour:
- Reset (rst=1, sampled at the clock edge):
  - Pointers and count clear to 0; ready_d clears to 0.
  - out_valid=0 and out_data=0.
  - in_ready=0 while rst is high; in_ready goes to 1 in the first cycle after rst deasserts.
  - Reset mid-operation discards all stored beats, with no partial output.
- Storage and status:
  - Read and write pointers are ADDR_W+1 bits wide, where ADDR_W=clog2(DEPTH); the MSB is the wrap bit.
  - count = wr_ptr - rd_ptr, modulo 2^(ADDR_W+1).
  - full: count==DEPTH. empty: count==0.
- Push:
  - push = in_valid & in_ready.
  - in_ready = ~full & ~rst, combinational from registered count; it does not depend on out_ready.
  - Pushing while full is impossible because in_ready=0.
- Output, READY_LATENCY=0:
  - out_valid = ~empty.
  - pop = out_valid & out_ready.
  - out_data holds its value while out_valid=1 and out_ready=0.
- Output, READY_LATENCY=1:
  - ready_d is a register of out_ready.
  - out_valid = ~empty & ready_d.
  - pop = out_valid; the sink must take every asserted beat.
  - out_valid=0 in any cycle following a cycle with out_ready=0.
- Latency:
  - A beat pushed into an empty FIFO at edge N is visible on out_valid in the cycle after N (RL=0), provided ready_d=1 (RL=1).
  - There is no combinational in-to-out fall-through.
- Simultaneous push and pop: count unchanged; both pointers advance.
  - When full: pop frees an entry, and in_ready rises the following cycle.
  - When count==1 with push and pop together: the FIFO stays non-empty and the next beat follows back-to-back.
- Wrap-around: pointers wrap naturally at 2^(ADDR_W+1); ordering is strictly FIFO.
- Throughput: full rate, one beat per clock, whenever upstream is valid and downstream is ready with FIFO not full.
- out_data when out_valid=0: holds the last head entry and is don't-care to the sink, but never X after reset.

Optional Feature:
- Macro: STREAM_FIFO_LEVEL_EN.
- Defined:
  - Adds output port fill_level [ADDR_W:0], carrying registered count (0..DEPTH), updated on the same edge as the pointers and reset to 0.
  - Adds sticky output overflow_seen, set if in_valid=1 while in_ready=0 for 64 or more consecutive cycles (stall monitor); cleared only by rst.
- Undefined: neither port nor its logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package stream_pkg:
  - clog2 constant function.
  - Localparams RL0=0 and RL1=1.
  - STALL_LIMIT=64.
- One sub-module, stream_fifo_mem: simple dual-port register array with DATA_WIDTH x DEPTH storage.
  - Synchronous write: we, waddr, wdata.
  - Asynchronous read: raddr to rdata.
  - Infers as MLAB/registers on the DE10.
- stream_fifo_rl holds the pointers, count, ready_d, handshake logic and the optional monitor.

Test Plan:
- Reset release: rst high for 3 cycles, then low → in_ready=0 during reset, 1 on the first cycle after; out_valid=0 throughout.
- Burst fill, DEPTH=4, RL=0, out_ready=0: push 0x1, 0x2, 0x3, 0x4, 0x5 → first four accepted; in_ready=0 after the fourth; 0x5 is held upstream.
- Drain in order: then out_ready=1 → out_data 0x1, 0x2, 0x3, 0x4, 0x5 on consecutive cycles; in_ready returns to 1 one cycle after the first pop.
- RL=1 gap: out_ready pattern 1,0,1,1 with 4 stored beats → out_valid pattern 0,1,0,1 (lagged one cycle); no beat lost or duplicated.
- Simultaneous push/pop at count==1, continuous valid/ready for 20 beats → count stays 1; output sequence equals input sequence; pointers wrap at least twice.
- Reset mid-stream with count=3 → after rst, out_valid=0, count=0; the next pushed beat 0xAA is the first output.
